// File: rtl/reg_debug_loader.sv
// Debounced pushbutton loader: captures switch data/index and issues one debug write into the register file.
// Optional LOADER_SIGN_EXT_EN sign-extends sw_data into dbg_wdata; by default it is zero-extended.
module reg_debug_loader #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_W            = 16,
  parameter int ACK_TIMEOUT     = 255,
  parameter int MAX_REG         = 25
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            btn_load,
  input  logic [SW_W-1:0] sw_data,
  input  logic [4:0]      sw_addr,
  output logic            dbg_we,
  output logic [4:0]      dbg_addr,
  output logic [31:0]     dbg_wdata,
  input  logic            dbg_ack,
  output logic            busy,
  output logic            err,
  output logic [7:0]      load_count
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [19:0] DB_LAST  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  TO_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [4:0]  MAX_ADDR = 5'(MAX_REG);

  logic        sync1_q, sync2_q;
  logic [19:0] db_cnt_q, db_cnt_d;
  logic        stable_q, stable_d;
  logic        pulse_q, pulse_d;
  state_t      state_q, state_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        we_q, we_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [7:0]  count_q, count_d;
  logic [31:0] ext_data;

`ifdef LOADER_SIGN_EXT_EN
  assign ext_data = 32'($signed(sw_data));
`else
  assign ext_data = 32'(sw_data);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_cnt_q <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      state_q  <= IDLE;
      tcnt_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      sync1_q  <= btn_load;
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // Only a debounced press (rising edge of the stable state) yields a load pulse.
  always_comb begin
    db_cnt_d = '0;
    stable_d = stable_q;
    pulse_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_LAST) begin
        stable_d = ~stable_q;
        pulse_d  = ~stable_q;
      end else begin
        db_cnt_d = db_cnt_q + 20'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (pulse_q) begin
          if (sw_addr <= MAX_ADDR) begin
            addr_d  = sw_addr;
            wdata_d = ext_data;
            we_d    = 1'b1;
            err_d   = 1'b0;
            tcnt_d  = '0;
            state_d = REQ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      REQ: begin
        // Ack wins over a simultaneous timeout expiry.
        if (dbg_ack) begin
          we_d    = 1'b0;
          count_d = count_q + 8'd1;
          state_d = DONE;
        end else if (tcnt_q == TO_LAST) begin
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dbg_we     = we_q;
  assign dbg_addr   = addr_q;
  assign dbg_wdata  = wdata_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign load_count = count_q;

endmodule

// File: doc/reg_debug_loader.md
Name: reg_debug_loader

Overview:
- Switch/button entry path into the CPU register file: the input-side counterpart of the register-to-seven-segment display path.
- Debounces a load button and captures a switch value plus register index.
- Drives a single-outstanding write request into the register file debug write port, using a req/ack handshake with timeout.
- Instantiated next to the CPU in the board top level, clocked from the divided system clock.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the button state is accepted (range 2..2^20).
- SW_W, 16, width of the switch data field (range 1..32).
- ACK_TIMEOUT, 255, maximum cycles dbg_we is held waiting for dbg_ack (range 1..255).
- MAX_REG, 25, highest legal register index (registers 0..25 exist).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_load  input  1  raw, bouncy, asynchronous load pushbutton; active high.
- sw_data  input  SW_W  raw switch data value.
- sw_addr  input  5  raw switch register index.
- dbg_we  output  1  write request to the register file debug port.
- dbg_addr  output  5  target register index; valid while dbg_we=1.
- dbg_wdata  output  32  write data; valid while dbg_we=1.
- dbg_ack  input  1  register file accepted the write; sampled only while dbg_we=1.
- busy  output  1  high whenever FSM is not IDLE.
- err  output  1  sticky error flag.
- load_count  output  8  number of completed (acked) writes; wraps.

Behaviour:
- Reset (async assert, sync release): dbg_we=0, dbg_addr=0, dbg_wdata=0, busy=0, err=0, load_count=0; debounce counter=0; stable button state=0; FSM=IDLE.
- btn_load passes through a 2-flop synchronizer. sw_data and sw_addr are sampled directly at capture; they are quasi-static.
- Debounce:
  - Counter clears whenever synced button equals stable state.
  - Otherwise counter increments. When it reaches DEBOUNCE_CYCLES-1, stable state flips and counter clears.
  - A 0->1 transition of stable state produces a one-cycle load_pulse. A 1->0 transition produces nothing.
- FSM states: IDLE, REQ, DONE.
- IDLE + load_pulse, sw_addr<=MAX_REG:
  - Next cycle: dbg_addr<=sw_addr, dbg_wdata<=zero-extended sw_data, dbg_we<=1, err<=0, timeout counter<=0.
  - Go to REQ. Latency from load_pulse to dbg_we is exactly 1 cycle.
- IDLE + load_pulse, sw_addr>MAX_REG:
  - No request issued; err<=1; load_count unchanged; stay IDLE.
- REQ:
  - dbg_we, dbg_addr and dbg_wdata are held constant.
  - dbg_ack=1 in a cycle: dbg_we<=0, load_count<=load_count+1 (255 wraps to 0), go to DONE.
  - Otherwise the timeout counter increments. When it equals ACK_TIMEOUT-1 without ack: dbg_we<=0, err<=1, go to DONE, load_count unchanged.
  - Ack arriving in the same cycle as timeout expiry counts as success.
- DONE: one cycle with busy=1 and dbg_we=0, then IDLE. This guarantees dbg_we has at least one low cycle between requests.
- load_pulse while busy: ignored and not queued. Button must be released and re-pressed.
- dbg_ack while dbg_we=0: ignored.
- dbg_addr and dbg_wdata keep their last values after a request completes.
- err is sticky. It is cleared only by reset or by the next accepted (legal-address) load_pulse.
- Reset mid-REQ: dbg_we drops immediately (asynchronous); nothing resumes after release.

Optional Feature:
- Macro: LOADER_SIGN_EXT_EN.
- Defined: dbg_wdata = sw_data sign-extended from bit SW_W-1 to 32 bits.
- Undefined (default): dbg_wdata = sw_data zero-extended to 32 bits.
- All other behaviour is identical either way.

Test Plan (DEBOUNCE_CYCLES=4, ACK_TIMEOUT=8, SW_W=16):
- Press btn_load with 3 glitches of 2 cycles each, then hold high 10 cycles; sw_addr=2, sw_data=16'h00A5; dbg_ack one cycle after dbg_we.
  - Expect exactly one request: dbg_addr=2, dbg_wdata=32'h000000A5.
  - Expect load_count=1, err=0, busy low 2 cycles after ack.
- sw_addr=26, press.
  - Expect dbg_we never asserts, err=1, load_count unchanged.
  - Next legal press: err clears the cycle dbg_we rises.
- Legal press, dbg_ack held 0.
  - Expect dbg_we high exactly 8 cycles, then low, err=1, load_count unchanged.
  - dbg_ack=1 pulsed on the 8th cycle instead: expect success, err=0.
- Second press while in REQ (ack delayed 5 cycles).
  - Expect single request only; load_count increments by 1.
- 256 acked loads.
  - Expect load_count wraps to 0.
- sw_data=16'h8001 with LOADER_SIGN_EXT_EN defined: expect dbg_wdata=32'hFFFF8001.
  - Without the macro: expect 32'h00008001.
- Assert rst_n low mid-REQ: expect dbg_we=0 asynchronously and all outputs at reset values.
